// File: rtl/subckt_bist_driver_pkg.sv
// rtl/subckt_bist_driver_pkg.sv - shared types, defaults and Galois step for the subcircuit BIST driver
//
// Purpose : state enum for the BIST sequencer, default LFSR seed and
//           polynomial, and the single Galois shift step used by both the
//           stimulus LFSR and the response MISR.
// Ports   : none (package).
// Config  : none.

package subckt_bist_pkg;

   // Working width of galois_step; callers zero-extend into it and pass
   // their real width in w.
   localparam int GALOIS_W  = 32;
   localparam int GALOIS_IW = $clog2(GALOIS_W);

   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
   localparam logic [15:0] DEFAULT_POLY = 16'hB400;

   typedef enum logic [2:0] {
      IDLE,
      DUT_RST,
      RUN,
      FLUSH,
      COMPARE,
      DONE
   } bist_state_e;

   // One Galois step of a w-bit register: shift left, fold in poly when the
   // outgoing msb is set, xor in the parallel input. Bits >= w are cleared.
   function automatic logic [GALOIS_W-1:0] galois_step(
      input logic [GALOIS_W-1:0] val,
      input logic [GALOIS_W-1:0] poly,
      input logic [GALOIS_W-1:0] in,
      input int unsigned         w = 16
   );
      logic [GALOIS_W-1:0] mask;
      logic [GALOIS_W-1:0] nxt;
      mask = ~({GALOIS_W{1'b1}} << w);
      nxt  = {val[GALOIS_W-2:0], 1'b0}
           ^ (val[GALOIS_IW'(w - 32'd1)] ? poly : '0)
           ^ in;
      return nxt & mask;
   endfunction

endpackage

// File: rtl/subckt_bist_driver_if.sv
// rtl/subckt_bist_driver_if.sv - control and subcircuit-facing signals of the BIST driver
//
// Purpose : bundles run control, status and the stimulus/response pair.
// Signals : start, abort        run request / cancel (towards driver)
//           resp[N_OUT]         subcircuit outputs (towards driver)
//           stim[N_IN]          subcircuit primary inputs (from driver)
//           dut_rst_n           subcircuit reset, active low (from driver)
//           busy, done, pass    status (from driver)
//           sig_out[SIG_W]      live MISR value, only with BIST_SIG_READBACK_EN
// Modports: master = BIST driver, slave = harness/subcircuit side.
// Config  : BIST_SIG_READBACK_EN adds sig_out and its width parameter.

interface subckt_bist_if #(
   parameter int N_IN  = 3,
   parameter int N_OUT = 1
`ifdef BIST_SIG_READBACK_EN
   , parameter int SIG_W = 16
`endif
);
   logic             start;
   logic             abort;
   logic [N_OUT-1:0] resp;
   logic [N_IN-1:0]  stim;
   logic             dut_rst_n;
   logic             busy;
   logic             done;
   logic             pass;
`ifdef BIST_SIG_READBACK_EN
   logic [SIG_W-1:0] sig_out;

   modport master (
      input  start, abort, resp,
      output stim, dut_rst_n, busy, done, pass, sig_out
   );
   modport slave (
      output start, abort, resp,
      input  stim, dut_rst_n, busy, done, pass, sig_out
   );
`else
   modport master (
      input  start, abort, resp,
      output stim, dut_rst_n, busy, done, pass
   );
   modport slave (
      output start, abort, resp,
      input  stim, dut_rst_n, busy, done, pass
   );
`endif
endinterface

// File: rtl/subckt_bist_driver_misr.sv
// rtl/subckt_bist_driver_misr.sv - multiple-input signature register for subcircuit responses
//
// Purpose : compacts the subcircuit outputs into a W-bit Galois signature.
// Ports   : clk        clock
//           rst        synchronous active-high reset (signature -> 0)
//           clr        clear signature (new run accepted); wins over en
//           en         capture din this cycle
//           din[N_OUT] subcircuit outputs, zero-extended into the step
//           sig[W]     current signature
// Config  : none.

module subckt_misr
   import subckt_bist_pkg::*;
#(
   parameter int           W     = 16,
   parameter int           N_OUT = 1,
   parameter logic [W-1:0] POLY  = DEFAULT_POLY
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [N_OUT-1:0] din,
   output logic [W-1:0]     sig
);

   logic [W-1:0] sig_q;
   logic [W-1:0] sig_d;

   always_comb begin
      sig_d = sig_q;
      if (clr) begin
         sig_d = '0;
      end else if (en) begin
         sig_d = W'(galois_step(GALOIS_W'(sig_q), GALOIS_W'(POLY), GALOIS_W'(din), W));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sig_q <= '0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig = sig_q;

endmodule

// File: rtl/subckt_bist_driver.sv
// rtl/subckt_bist_driver.sv - LFSR stimulus / MISR response BIST driver for one extracted subcircuit
//
// Purpose : on start, holds the subcircuit in reset for RST_CYC cycles,
//           applies N_VEC pseudo-random vectors, waits LAT cycles for the
//           pipeline to drain, compacts exactly N_VEC responses into a MISR
//           and compares the signature with GOLDEN_SIG.
// Ports   : I1470_clk  clock
//           I1477_rst  synchronous active-high reset
//           bist       subckt_bist_if.master: start, abort, resp in;
//                      stim, dut_rst_n, busy, done, pass (and sig_out) out
// Config  : BIST_SIG_READBACK_EN drives bist.sig_out with the live MISR.

module subckt_bist_driver
   import subckt_bist_pkg::*;
#(
   parameter int                N_IN       = 3,
   parameter int                N_OUT      = 1,
   parameter int                LFSR_W     = 16,
   parameter logic [LFSR_W-1:0] SEED       = DEFAULT_SEED,
   parameter logic [LFSR_W-1:0] POLY       = DEFAULT_POLY,
   parameter int                N_VEC      = 1000,
   parameter int                LAT        = 2,
   parameter int                RST_CYC    = 2,
   parameter logic [LFSR_W-1:0] GOLDEN_SIG = '0
) (
   input logic            I1470_clk,
   input logic            I1477_rst,
   subckt_bist_if.master  bist
);

   localparam int VW   = $clog2(N_VEC + 1);
   localparam int CMAX = (RST_CYC > LAT) ? RST_CYC : LAT;
   localparam int CW   = $clog2(CMAX + 1);

   localparam logic [VW-1:0] VEC_LAST   = VW'(N_VEC - 1);
   localparam logic [VW-1:0] VEC_MAX    = VW'(N_VEC);
   localparam logic [CW-1:0] RST_LAST   = CW'(RST_CYC - 1);
   localparam logic [CW-1:0] FLUSH_LAST = CW'(LAT - 1);

   bist_state_e       state_q,     state_d;
   logic [CW-1:0]     cnt_q,       cnt_d;
   logic [VW-1:0]     vec_cnt_q,   vec_cnt_d;
   logic [LFSR_W-1:0] lfsr_q,      lfsr_d;
   logic [N_IN-1:0]   stim_q,      stim_d;
   logic              dut_rst_n_q, dut_rst_n_d;
   logic              busy_q,      busy_d;
   logic              done_q,      done_d;
   logic              pass_q,      pass_d;

   logic              misr_clr;
   logic              cap_en;
   logic [LFSR_W-1:0] misr_sig;
   logic [LFSR_W-1:0] lfsr_step;

   // Vector i is applied in RUN cycle i and its response appears LAT cycles
   // later, so capture covers RUN cycles >= LAT plus the FLUSH cycles whose
   // overall index (N_VEC + flush index) is still >= LAT.
   always_comb begin
      cap_en = ((state_q == RUN)   && (int'(vec_cnt_q) >= LAT))
            || ((state_q == FLUSH) && (int'(cnt_q) + N_VEC >= LAT));
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      vec_cnt_d = vec_cnt_q;
      lfsr_d    = lfsr_q;
      pass_d    = pass_q;
      misr_clr  = 1'b0;
      lfsr_step = LFSR_W'(galois_step(GALOIS_W'(lfsr_q), GALOIS_W'(POLY), '0, LFSR_W));

      case (state_q)
         IDLE: begin
            if (bist.start) begin
               state_d   = DUT_RST;
               cnt_d     = '0;
               vec_cnt_d = '0;
               lfsr_d    = SEED;
               pass_d    = 1'b0;
               misr_clr  = 1'b1;
            end
         end
         DUT_RST: begin
            if (cnt_q == RST_LAST) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RUN: begin
            if (vec_cnt_q != VEC_MAX) begin
               vec_cnt_d = vec_cnt_q + 1'b1;
            end
            if (vec_cnt_q == VEC_LAST) begin
               state_d = (LAT > 0) ? FLUSH : COMPARE;
            end
         end
         FLUSH: begin
            if (cnt_q == FLUSH_LAST) begin
               state_d = COMPARE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         COMPARE: begin
            pass_d  = (misr_sig == GOLDEN_SIG);
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if ((state_q != IDLE) && bist.abort) begin
         state_d = IDLE;
         pass_d  = 1'b0;
      end

      // Outputs are registered from the next state, so stim shows the
      // pre-advance LFSR value in the same cycle the FSM sits in RUN.
      if (state_d == RUN) begin
         lfsr_d = lfsr_step;
      end
      stim_d      = (state_d == RUN) ? lfsr_q[N_IN-1:0] : '0;
      dut_rst_n_d = (state_d != DUT_RST);
      busy_d      = (state_d != IDLE);
      done_d      = (state_d == DONE);
   end

   always_ff @(posedge I1470_clk) begin
      if (I1477_rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         vec_cnt_q   <= '0;
         lfsr_q      <= SEED;
         stim_q      <= '0;
         dut_rst_n_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         vec_cnt_q   <= vec_cnt_d;
         lfsr_q      <= lfsr_d;
         stim_q      <= stim_d;
         dut_rst_n_q <= dut_rst_n_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
      end
   end

   subckt_misr #(
      .W     (LFSR_W),
      .N_OUT (N_OUT),
      .POLY  (POLY)
   ) u_misr (
      .clk (I1470_clk),
      .rst (I1477_rst),
      .clr (misr_clr),
      .en  (cap_en),
      .din (bist.resp),
      .sig (misr_sig)
   );

   assign bist.stim      = stim_q;
   assign bist.dut_rst_n = dut_rst_n_q;
   assign bist.busy      = busy_q;
   assign bist.done      = done_q;
   assign bist.pass      = pass_q;
`ifdef BIST_SIG_READBACK_EN
   assign bist.sig_out   = misr_sig;
`endif

endmodule

// File: tb/tb_subckt_bist_driver.sv
// tb/tb_subckt_bist_driver.sv - directed self-checking bench for subckt_bist_driver

module tb_subckt_bist_driver;

   logic clk;
   logic rst;

   int errors = 0;
   int checks = 0;

   // Per-cycle expectations, cycle 0 = cycle in which start is sampled.
   // stim: SEED 0xACE1 -> 0xEDC2 -> 0x6F84 -> 0xDF08, low 3 bits.
   int exp_stim [12] = '{0, 0, 0, 1, 2, 4, 0, 0, 0, 0, 0, 0};
   int exp_drn  [12] = '{1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
   int exp_busy [12] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
   int exp_done [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
   // MISR with resp=1 captured at the end of cycles 5..8: 0->1->3->7->F.
   int exp_sig1 [12] = '{0, 0, 0, 0, 0, 0, 1, 3, 7, 15, 15, 15};

   subckt_bist_if #(.N_IN(3), .N_OUT(1)) bif ();

   subckt_bist_driver #(
      .N_IN       (3),
      .N_OUT      (1),
      .LFSR_W     (16),
      .SEED       (16'hACE1),
      .POLY       (16'hB400),
      .N_VEC      (4),
      .LAT        (2),
      .RST_CYC    (2),
      .GOLDEN_SIG (16'h0000)
   ) dut (
      .I1470_clk (clk),
      .I1477_rst (rst),
      .bist      (bif.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_stim"}, 32'(bif.stim), 32'd0);
      chk({tag, "_drn"},  32'(bif.dut_rst_n), 32'd0);
      chk({tag, "_busy"}, 32'(bif.busy), 32'd0);
      chk({tag, "_done"}, 32'(bif.done), 32'd0);
      chk({tag, "_pass"}, 32'(bif.pass), 32'd0);
`ifdef BIST_SIG_READBACK_EN
      chk({tag, "_sig"},  32'(bif.sig_out), 32'd0);
`endif
   endtask

   // Entered at a negedge in IDLE; that cycle is cycle 0. Returns in cycle 11.
   task automatic do_run(input logic rv, input logic exp_pass, input bit hold_start);
      int n_done;
      n_done    = 0;
      bif.resp  = rv;
      bif.start = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         bif.start = hold_start && (c >= 2) && (c <= 10);
         chk($sformatf("stim@%0d", c), 32'(bif.stim), 32'(exp_stim[c]));
         chk($sformatf("drn@%0d", c),  32'(bif.dut_rst_n), 32'(exp_drn[c]));
         chk($sformatf("busy@%0d", c), 32'(bif.busy), 32'(exp_busy[c]));
         chk($sformatf("done@%0d", c), 32'(bif.done), 32'(exp_done[c]));
         if (bif.done) n_done++;
         if (c == 1) chk("pass_clr", 32'(bif.pass), 32'd0);
         if (c >= 10) chk($sformatf("pass@%0d", c), 32'(bif.pass), 32'(exp_pass));
`ifdef BIST_SIG_READBACK_EN
         chk($sformatf("sig@%0d", c), 32'(bif.sig_out), rv ? 32'(exp_sig1[c]) : 32'd0);
`endif
      end
      chk("done_once", 32'(n_done), 32'd1);
   endtask

   task automatic idle_cycles(input string tag, input int n);
      int n_done;
      n_done = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (bif.done) n_done++;
      end
      chk({tag, "_no_done"}, 32'(n_done), 32'd0);
      chk({tag, "_idle"}, 32'(bif.busy), 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      bif.start = 1'b0;
      bif.abort = 1'b0;
      bif.resp  = '0;

      repeat (3) @(negedge clk);
      chk_reset_vals("rst");
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_drn", 32'(bif.dut_rst_n), 32'd1);
      chk("post_rst_busy", 32'(bif.busy), 32'd0);

      do_run(1'b0, 1'b1, 1'b0);
      do_run(1'b1, 1'b0, 1'b0);
      do_run(1'b0, 1'b1, 1'b1);
      idle_cycles("hold", 4);

      // abort in the second RUN cycle (cycle 4)
      bif.resp  = 1'b0;
      bif.start = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         bif.start = 1'b0;
         if (c == 4) bif.abort = 1'b1;
      end
      @(negedge clk);
      bif.abort = 1'b0;
      chk("abort_busy", 32'(bif.busy), 32'd0);
      chk("abort_stim", 32'(bif.stim), 32'd0);
      chk("abort_pass", 32'(bif.pass), 32'd0);
      chk("abort_done", 32'(bif.done), 32'd0);
      idle_cycles("abort", 12);
      do_run(1'b0, 1'b1, 1'b0);

      // synchronous reset while in FLUSH (cycle 7)
      bif.resp  = 1'b1;
      bif.start = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         bif.start = 1'b0;
      end
      chk("flush_stim", 32'(bif.stim), 32'd0);
      chk("flush_busy", 32'(bif.busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_vals("flush_rst");
      rst = 1'b0;
      idle_cycles("flush_rst", 12);

      do_run(1'b1, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
